// File: rtl/counter_event_fifo.sv
// counter_event_fifo: captures {event mask, count, timestamp} on every rising
// edge of any counter event flag into a small first-word-fall-through FIFO.
// The host drains it through the head_* outputs and a single-cycle pop pulse.
// Optional build macro COUNTER_EVENT_FIFO_DROP_COUNT_EN adds a saturating
// dropped-event counter (dropped_cnt).
module counter_event_fifo #(
  parameter int EVT_W      = 2,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [EVT_W-1:0]      evt_in,
  input  logic [CNT_W-1:0]      count_in,
  input  logic                  pop,
  input  logic                  clear,
  output logic [EVT_W-1:0]      head_evt,
  output logic [CNT_W-1:0]      head_count,
  output logic [TS_W-1:0]       head_ts,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
`ifdef COUNTER_EVENT_FIFO_DROP_COUNT_EN
  ,
  output logic [7:0]            dropped_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ENT_W = EVT_W + CNT_W + TS_W;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [TS_W-1:0]       TS_ONE   = 1;

  logic [ENT_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [TS_W-1:0]       ts;
  logic [EVT_W-1:0]      evt_q;
  logic [EVT_W-1:0]      rise;
  logic                  push;
  logic                  do_push;
  logic                  do_pop;
  logic                  drop;
  logic [ENT_W-1:0]      head;

  // A pop frees a slot on the same edge, so a push into a full FIFO
  // alongside a pop is accepted rather than dropped.
  assign rise    = evt_in & ~evt_q;
  assign push    = |rise;
  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  // Head view is a mux of registered storage by the registered read pointer,
  // gated by the registered level, so no input reaches the outputs.
  assign head       = mem[rd_ptr];
  assign head_evt   = empty ? '0 : head[ENT_W-1 -: EVT_W];
  assign head_count = empty ? '0 : head[TS_W+CNT_W-1 -: CNT_W];
  assign head_ts    = empty ? '0 : head[TS_W-1:0];

  // Previous event levels for edge detection; tracks the input even during clear.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) evt_q <= '0;
    else       evt_q <= evt_in;
  end

  // Free-running wrapping timestamp, restarted by clear.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)      ts <= '0;
    else if (clear) ts <= '0;
    else            ts <= ts + TS_ONE;
  end

  // Pointer, occupancy and sticky overflow bookkeeping; clear wins over push/pop.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Entry storage; contents need no reset because empty masks the head view.
  always_ff @(posedge sys_clk) begin
    if (do_push && !clear) mem[wr_ptr] <= {rise, count_in, ts};
  end

`ifdef COUNTER_EVENT_FIFO_DROP_COUNT_EN
  // Saturating count of events lost to a full FIFO.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)                            dropped_cnt <= '0;
    else if (clear)                       dropped_cnt <= '0;
    else if (drop && dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_counter_event_fifo.sv
// Bench for counter_event_fifo: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_counter_event_fifo;

  localparam int EVT_W = 2;
  localparam int CNT_W = 8;
  localparam int TS_W  = 16;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ENT_W = EVT_W + CNT_W + TS_W;

  logic                 sys_clk = 1'b0;
  logic                 reset;
  logic [EVT_W-1:0]     evt_in;
  logic [CNT_W-1:0]     count_in;
  logic                 pop;
  logic                 clear;
  logic [EVT_W-1:0]     head_evt;
  logic [CNT_W-1:0]     head_count;
  logic [TS_W-1:0]      head_ts;
  logic                 empty;
  logic                 full;
  logic [DEPTH_LOG2:0]  level;
  logic                 overflow;
`ifdef COUNTER_EVENT_FIFO_DROP_COUNT_EN
  logic [7:0]           dropped_cnt;
`endif

  counter_event_fifo #(
    .EVT_W(EVT_W), .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .evt_in     (evt_in),
    .count_in   (count_in),
    .pop        (pop),
    .clear      (clear),
    .head_evt   (head_evt),
    .head_count (head_count),
    .head_ts    (head_ts),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .overflow   (overflow)
`ifdef COUNTER_EVENT_FIFO_DROP_COUNT_EN
    ,
    .dropped_cnt(dropped_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [ENT_W-1:0] q[$];
  logic [EVT_W-1:0] m_evt;
  logic [TS_W-1:0]  m_ts;
  logic             m_ovf;
  int               m_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_evt = '0; m_ts = '0; m_ovf = 1'b0; m_drop = 0;
  endtask

  // One clock edge of the FIFO as described behaviourally.
  task automatic model_edge();
    logic [EVT_W-1:0] r;
    r = evt_in & ~m_evt;
    if (clear) begin
      q.delete();
      m_ovf = 1'b0; m_ts = '0; m_drop = 0;
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (r != '0) begin
        if (q.size() < DEPTH) q.push_back({r, count_in, m_ts});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_ts = m_ts + 1'b1;
    end
    m_evt = evt_in;
  endtask

  task automatic compare_all();
    logic [ENT_W-1:0] h;
    h = (q.size() > 0) ? q[0] : '0;
    check("head_evt",   32'(head_evt),   32'(h[ENT_W-1 -: EVT_W]));
    check("head_count", 32'(head_count), 32'(h[TS_W+CNT_W-1 -: CNT_W]));
    check("head_ts",    32'(head_ts),    32'(h[TS_W-1:0]));
    check("level",      32'(level),      32'(q.size()));
    check("empty",      32'(empty),      32'(q.size() == 0));
    check("full",       32'(full),       32'(q.size() == DEPTH));
    check("overflow",   32'(overflow),   32'(m_ovf));
`ifdef COUNTER_EVENT_FIFO_DROP_COUNT_EN
    check("dropped_cnt", 32'(dropped_cnt), 32'(m_drop));
`endif
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic idle();
    evt_in = '0; pop = 1'b0; clear = 1'b0;
  endtask

  // Low cycle then rising edge of bits, optionally with pop on the rising edge.
  task automatic rise_evt(input logic [EVT_W-1:0] bits, input logic [CNT_W-1:0] cnt, input logic p);
    evt_in = '0; pop = 1'b0; clear = 1'b0;
    step();
    evt_in = bits; count_in = cnt; pop = p;
    step();
    pop = 1'b0;
  endtask

  task automatic do_clear();
    idle(); clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; evt_in = 2'b01; count_in = 8'h00; pop = 1'b0; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    compare_all();

    // Event held high across reset release: one entry only
    reset = 1'b0;
    repeat (100) step();
    check("t1_level", 32'(level), 32'd1);
    check("t1_evt",   32'(head_evt), 32'd1);
    check("t1_ts",    32'(head_ts), 32'd0);

    // Simultaneous rise with count 80 at ts 5, then pop
    do_clear();
    repeat (5) step();
    evt_in = 2'b11; count_in = 8'h80;
    step();
    check("t2_evt",   32'(head_evt), 32'h3);
    check("t2_count", 32'(head_count), 32'h80);
    check("t2_ts",    32'(head_ts), 32'h5);
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_head0", 32'(head_ts), 32'd0);

    // 17 pushes: full after 16, overflow after 17, ordered drain
    do_clear();
    for (int i = 0; i < 17; i++) begin
      rise_evt(2'b01, 8'(i), 1'b0);
      if (i == 15) check("t3_full16", 32'(full), 32'd1);
    end
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t3_order", 32'(head_count), 32'(i));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    check("t3_empty", 32'(empty), 32'd1);

    // Full with simultaneous push and pop
    do_clear();
    for (int i = 0; i < 16; i++) rise_evt(2'b10, 8'(i + 16), 1'b0);
    rise_evt(2'b01, 8'hAA, 1'b1);
    check("t4_level", 32'(level), 32'd16);
    check("t4_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t4_last", 32'(head_count), 32'hAA);
      pop = 1'b1;
      step();
    end
    pop = 1'b0;

    // Pop on empty, then clear beats push and pop
    do_clear();
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("t5_popempty", 32'(level), 32'd0);
    for (int i = 0; i < 5; i++) rise_evt(2'b01, 8'(i), 1'b0);
    check("t5_level5", 32'(level), 32'd5);
    evt_in = '0;
    step();
    evt_in = 2'b11; pop = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; pop = 1'b0;
    check("t5_clr_level", 32'(level), 32'd0);
    check("t5_clr_ovf", 32'(overflow), 32'd0);
    evt_in = '0;
    step();
    evt_in = 2'b10; count_in = 8'h33;
    step();
    check("t5_ts_restart", 32'(head_ts), 32'd1);

`ifdef COUNTER_EVENT_FIFO_DROP_COUNT_EN
    // Saturating drop counter
    do_clear();
    for (int i = 0; i < 16; i++) rise_evt(2'b01, 8'(i), 1'b0);
    for (int i = 0; i < 300; i++) rise_evt(2'b01, 8'(i), 1'b0);
    check("t6_sat", 32'(dropped_cnt), 32'hFF);
    do_clear();
    check("t6_clr", 32'(dropped_cnt), 32'h00);
`endif

    // Randomized traffic
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      evt_in   = EVT_W'($urandom);
      count_in = CNT_W'($urandom);
      pop      = ($urandom_range(0, 2) == 0);
      clear    = ($urandom_range(0, 199) == 0);
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
